gate_sweep_checker: RTL
=======================

# gate_sweep_checker

Self-checking sweep engine for the gate-level lab blocks. It drives every input vector of a parametrised-width stimulus bus into two gate implementations that share that bus (reference and candidate). After a settle delay it compares their output buses, counts mismatching vectors and captures the first failure. It replaces the hand-written four-vector stimulus and manual `$monitor` inspection with a synthesizable, N-input, N-output checker that supports binary or Gray-code sweep order.

## Interface
Parameters:
- IN_W, 2, stimulus width; sweep covers 2^IN_W vectors (1..16)
- OUT_W, 6, number of compared output bits
- SETTLE, 1, cycles a vector is held before comparison (>=1)
- CNT_W, 16, mismatch counter width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  begin sweep; sampled in IDLE or DONE only
- gray  input  1  sweep order latched at accepted start: 0 = binary ascending, 1 = Gray code
- stim  output  IN_W  vector driven to both implementations
- ref_out  input  OUT_W  reference implementation outputs
- dut_out  input  OUT_W  candidate implementation outputs
- busy  output  1  sweep in progress
- done  output  1  sweep complete; level, held until next accepted start or rst
- pass  output  1  done && err_count==0
- err_count  output  CNT_W  number of mismatching vectors, saturating
- first_fail_vec  output  IN_W  stim value of the first mismatch
- first_fail_mask  output  OUT_W  ref_out^dut_out at the first mismatch

## Operation
- States: IDLE, APPLY, CHECK, DONE.
- IDLE/DONE + start=1:
  - next state APPLY; index=0; settle counter=0.
  - err_count, first_fail_vec and first_fail_mask cleared; done=0.
  - gray latched into mode register.
- APPLY: holds stim for SETTLE cycles, then moves to CHECK.
- CHECK, one cycle:
  - mm = ref_out ^ dut_out, evaluated combinationally and registered at the edge leaving CHECK.
  - If mm!=0: err_count += 1, saturating at 2^CNT_W-1.
  - If mm!=0 and this is the first mismatch of the sweep: capture stim and mm.
  - If index == 2^IN_W-1, go to DONE; otherwise index += 1 and go to APPLY.
- stim = index in binary mode; stim = index ^ (index>>1) in Gray mode, so exactly one bit toggles per step.
- A mismatch is counted per vector, not per output bit.
- start while busy is ignored.
- gray is ignored except at an accepted start.

## Timing
- Reset values: stim=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_mask=0, state IDLE.
- rst mid-sweep: all outputs return to reset values at the next edge. No partial result is retained.
- Start accepted at edge T:
  - busy=1 and stim=vector 0 from T+1.
  - Each vector occupies SETTLE+1 cycles (APPLY×SETTLE, CHECK×1).
  - done=1 and busy=0 at T+1+2^IN_W·(SETTLE+1).
- stim is registered and changes only on the edge leaving CHECK, or on start.
- err_count and the capture fields update on the edge leaving CHECK.
- They are final in the same cycle done rises.
- pass is combinational from done and err_count.
- Last vector: wrap of index is not used; the FSM exits to DONE and stim holds the last vector.

## Structure
- Package gate_sweep_pkg:
  - state enum (IDLE, APPLY, CHECK, DONE)
  - MODE_BIN=0, MODE_GRAY=1
  - function bin2gray(IN_W)
- Sub-module gate_sweep_seq: index counter, settle counter, Gray encoder, last-vector flag.
- Top: FSM, comparator, saturating counter, first-fail capture.
- The bench instantiates the existing AND/OR/NOT gate pairs on stim[1:0], concatenated into ref_out/dut_out.

## Test plan
- Identical-outputs sweep, IN_W=2, SETTLE=1, gray=0, ref_out==dut_out always:
  - stim sequence 0,1,2,3, each held 2 cycles.
  - done exactly 8 cycles after start edge+1; err_count=0, pass=1.
- Single injected mismatch, dut_out bit 3 flipped only when stim==2'b10:
  - err_count=1, pass=0.
  - first_fail_vec=2'b10, first_fail_mask=6'b001000.
- Gray order, gray=1, IN_W=3:
  - stim sequence 000,001,011,010,110,111,101,100.
  - Exactly one bit changes per step.
- Saturation, CNT_W=2, IN_W=3, dut_out=~ref_out always:
  - err_count stops at 3.
  - first_fail_vec=0, first_fail_mask=all ones.
- Reset mid-sweep: rst=1 while stim==2 with err_count=1.
  - Next cycle all outputs are zero and state is IDLE.
  - A fresh start sweeps from vector 0.
- Start ignored and restart from DONE:
  - start pulsed during APPLY: no restart, completion cycle unchanged.
  - start pulsed in DONE: done drops next cycle and counters clear.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared types and helpers for the gate sweep checker.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  localparam int MAX_IN_W = 16;

  // Callers zero-extend into MAX_IN_W and keep only their low bits.
  function automatic logic [MAX_IN_W-1:0] bin2gray(input logic [MAX_IN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gate_sweep_seq.sv
// Vector sequencer: index counter, settle counter, Gray encoder and last-vector flag.
module gate_sweep_seq
  import gate_sweep_pkg::*;
#(
  parameter int IN_W   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            hold,
  input  logic            advance,
  input  logic            mode,
  output logic [IN_W-1:0] stim,
  output logic            settle_done,
  output logic            last_vec
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  logic [IN_W-1:0] idx_q, idx_d;
  logic [IN_W-1:0] stim_q, stim_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [IN_W-1:0] nxt_idx;

  assign nxt_idx     = idx_q + IN_W'(1);
  assign settle_done = (settle_q == SETTLE_LAST);
  assign last_vec    = (idx_q == {IN_W{1'b1}});
  assign stim        = stim_q;

  always_comb begin
    idx_d    = idx_q;
    stim_d   = stim_q;
    settle_d = settle_q;
    if (clear) begin
      idx_d    = '0;
      stim_d   = '0;
      settle_d = '0;
    end else if (advance) begin
      idx_d    = nxt_idx;
      settle_d = '0;
      if (mode == MODE_GRAY) begin
        stim_d = IN_W'(bin2gray(MAX_IN_W'(nxt_idx)));
      end else begin
        stim_d = nxt_idx;
      end
    end else if (hold && !settle_done) begin
      settle_d = settle_q + SW'(1);
    end else begin
      settle_d = settle_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      stim_q   <= '0;
      settle_q <= '0;
    end else begin
      idx_q    <= idx_d;
      stim_q   <= stim_d;
      settle_q <= settle_d;
    end
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweep engine: drives every stimulus vector, compares reference vs candidate
// outputs, counts mismatching vectors and captures the first failure.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int IN_W   = 2,
  parameter int OUT_W  = 6,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gray,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] ref_out,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [IN_W-1:0]  first_fail_vec,
  output logic [OUT_W-1:0] first_fail_mask
);

  localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [IN_W-1:0]  ffv_q, ffv_d;
  logic [OUT_W-1:0] ffm_q, ffm_d;

  logic             clear, hold, advance;
  logic             settle_done, last_vec;
  logic [OUT_W-1:0] mm;

  assign mm = ref_out ^ dut_out;

  gate_sweep_seq #(
    .IN_W   (IN_W),
    .SETTLE (SETTLE)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .hold        (hold),
    .advance     (advance),
    .mode        (mode_q),
    .stim        (stim),
    .settle_done (settle_done),
    .last_vec    (last_vec)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffm_d   = ffm_q;
    clear   = 1'b0;
    hold    = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_APPLY;
          clear   = 1'b1;
          mode_d  = gray;
          err_d   = '0;
          ffv_d   = '0;
          ffm_d   = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_APPLY: begin
        hold = 1'b1;
        if (settle_done) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_APPLY;
        end
      end
      ST_CHECK: begin
        // The counter saturates, so a zero count reliably marks the first mismatch.
        if (mm != '0) begin
          if (err_q == '0) begin
            ffv_d = stim;
            ffm_d = mm;
          end else begin
            ffv_d = ffv_q;
          end
          if (err_q != ERR_MAX) begin
            err_d = err_q + CNT_W'(1);
          end else begin
            err_d = err_q;
          end
        end else begin
          err_d = err_q;
        end
        if (last_vec) begin
          state_d = ST_DONE;
        end else begin
          advance = 1'b1;
          state_d = ST_APPLY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_APPLY) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_BIN;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffm_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffm_q   <= ffm_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = done_q && (err_q == '0);
  assign err_count       = err_q;
  assign first_fail_vec  = ffv_q;
  assign first_fail_mask = ffm_q;

endmodule
